// File: rtl/ttl_sync_counter.sv
// ttl_sync_counter: parametrised synchronous counter in the 74160/161/190/191 style.
// Features: WIDTH/MODULUS, up/down, synchronous load, ENP/ENT enables,
// combinational ripple-carry out and asynchronous active-low clear.
// Optional macro TTL_SYNC_COUNTER_OVF_EN adds a sticky wrap flag output OVF.
module ttl_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
`ifdef TTL_SYNC_COUNTER_OVF_EN
  ,
  output logic             OVF
`endif
);

  // Terminal values held in WIDTH bits; MODULUS=2**WIDTH gives MAX_Q = all ones.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // Reject illegal parameter combinations while the design is elaborated.
  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
    $fatal(1, "ttl_sync_counter: MODULUS must lie in 2..2**WIDTH and WIDTH in 1..16");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             rco_s;

  // Next-state selection: load beats count, count needs both enables, else hold.
  always_comb begin
    q_next_s = q_r;
    if (!LOAD_N) begin
      q_next_s = D;
    end else if (ENP && ENT) begin
      if (UP) begin
        if (q_r >= MAX_Q) begin
          q_next_s = ZERO;
        end else begin
          q_next_s = q_r + ONE;
        end
      end else begin
        // Zero and any out-of-range loaded value both land on the top state.
        if (q_r == ZERO || q_r > MAX_Q) begin
          q_next_s = MAX_Q;
        end else begin
          q_next_s = q_r - ONE;
        end
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Counter state register with asynchronous clear.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      q_r <= ZERO;
    end else begin
      q_r <= q_next_s;
    end
  end

  // Ripple carry follows Q, ENT and UP without waiting for a clock edge.
  always_comb begin
    rco_s = 1'b0;
    if (!ENT) begin
      rco_s = 1'b0;
    end else if (UP) begin
      rco_s = (q_r == MAX_Q);
    end else begin
      rco_s = (q_r == ZERO);
    end
  end

  assign Q   = q_r;
  assign RCO = rco_s;

`ifdef TTL_SYNC_COUNTER_OVF_EN
  logic ovf_r;
  logic wrap_s;

  // A wrap is a count step leaving the top (or beyond) going up, or zero going down.
  always_comb begin
    wrap_s = 1'b0;
    if (LOAD_N && ENP && ENT) begin
      wrap_s = UP ? (q_r >= MAX_Q) : (q_r == ZERO);
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Sticky wrap flag: cleared by clear or any load, set by a wrapping step.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ovf_r <= 1'b0;
    end else if (!LOAD_N) begin
      ovf_r <= 1'b0;
    end else if (wrap_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign OVF = ovf_r;
`endif

endmodule

// File: tb/tb_ttl_sync_counter.sv
// Self-checking bench for ttl_sync_counter (WIDTH=4, MODULUS=10) plus a
// two-digit cascade. OVF checks are compiled in with TTL_SYNC_COUNTER_OVF_EN.
module tb_ttl_sync_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr_n, load_n, enp, ent, up;
  logic [W-1:0] d, q;
  logic         rco;
  logic         c_load_n, c_enp;
  logic [W-1:0] c_d, u_q, t_q;
  logic         u_rco, t_rco;
`ifdef TTL_SYNC_COUNTER_OVF_EN
  logic ovf, u_ovf, t_ovf;
`endif

  ttl_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(load_n), .ENP(enp), .ENT(ent), .UP(up),
    .D(d), .Q(q), .RCO(rco)
`ifdef TTL_SYNC_COUNTER_OVF_EN
    , .OVF(ovf)
`endif
  );

  ttl_sync_counter #(.WIDTH(W), .MODULUS(M)) units (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(c_load_n), .ENP(c_enp), .ENT(1'b1), .UP(1'b1),
    .D(c_d), .Q(u_q), .RCO(u_rco)
`ifdef TTL_SYNC_COUNTER_OVF_EN
    , .OVF(u_ovf)
`endif
  );

  ttl_sync_counter #(.WIDTH(W), .MODULUS(M)) tens (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(c_load_n), .ENP(c_enp), .ENT(u_rco), .UP(1'b1),
    .D(c_d), .Q(t_q), .RCO(t_rco)
`ifdef TTL_SYNC_COUNTER_OVF_EN
    , .OVF(t_ovf)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load_n = 1'b0;
    d = W'(v);
    tick();
    load_n = 1'b1;
  endtask

  // Modulo counting rule in plain integers.
  function automatic int ref_step(input int v, input bit dir_up);
    if (dir_up) return (v >= M - 1) ? 0 : v + 1;
    else        return (v == 0 || v >= M) ? M - 1 : v - 1;
  endfunction

  int m, mo, n, c_ovf;
  bit wrapped;
  int exp_down[4] = '{1, 0, 9, 8};

  initial begin
    clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; up = 1'b1; d = '0;
    c_load_n = 1'b1; c_enp = 1'b0; c_d = '0;
    #12;
    check_eq("reset_q", q, 0);
    check_eq("reset_rco_ent0", rco, 0);
    ent = 1'b1; up = 1'b0; #1;
    check_eq("reset_rco_down", rco, 1);
    clr_n = 1'b1;
    tick();

    // Asynchronous clear between edges.
    enp = 1'b0; up = 1'b1;
    do_load(7);
    check_eq("load7", q, 7);
    #2 clr_n = 1'b0; ent = 1'b1; up = 1'b0;
    #1;
    check_eq("async_clr_q", q, 0);
    check_eq("async_clr_rco", rco, 1);
`ifdef TTL_SYNC_COUNTER_OVF_EN
    check_eq("async_clr_ovf", ovf, 0);
`endif
    #1 clr_n = 1'b1;

    // Up count through the wrap.
    tick();
    up = 1'b1; enp = 1'b1; ent = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq("up_q", q, i % 10);
      check_eq("up_rco", rco, (i % 10) == 9);
    end
`ifdef TTL_SYNC_COUNTER_OVF_EN
    check_eq("up_wrap_ovf", ovf, 1);
`endif

    // Load priority and out-of-range recovery.
    do_load(12);
    check_eq("load12", q, 12);
`ifdef TTL_SYNC_COUNTER_OVF_EN
    check_eq("load_clears_ovf", ovf, 0);
`endif
    up = 1'b1; tick();
    check_eq("oor_up", q, 0);
    do_load(12);
    up = 1'b0; tick();
    check_eq("oor_down", q, 9);
`ifdef TTL_SYNC_COUNTER_OVF_EN
    check_eq("oor_down_no_ovf", ovf, 0);
`endif

    // Enable gating.
    do_load(5);
    enp = 1'b0; ent = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("enp0_q", q, 5);
      check_eq("enp0_rco", rco, 0);
    end
    enp = 1'b1; ent = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ent0_q", q, 5);
    end
    do_load(9);
    #1;
    check_eq("rco_ent0_q9", rco, 0);
    ent = 1'b1; #1;
    check_eq("rco_ent1_q9", rco, 1);
    up = 1'b0; #1;
    check_eq("rco_dir_change", rco, 0);

    // Down count through zero.
    enp = 1'b0;
    do_load(2);
    enp = 1'b1; ent = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("down_q", q, exp_down[i]);
      check_eq("down_rco", rco, exp_down[i] == 0);
    end

    // Randomised run against the integer model.
    m = int'($urandom_range(15));
    do_load(m);
    mo = 0;
    for (int k = 0; k < 400; k++) begin
      load_n = ($urandom_range(7) == 0) ? 1'b0 : 1'b1;
      enp = ($urandom_range(3) != 0);
      ent = ($urandom_range(3) != 0);
      up = 1'($urandom_range(1));
      d = W'($urandom_range(15));
      #1;
      check_eq("rnd_rco", rco, ent && (up ? (m == M - 1) : (m == 0)));
      if ($urandom_range(15) == 0) begin
        clr_n = 1'b0;
        #1;
        check_eq("rnd_clr_q", q, 0);
        m = 0; mo = 0;
        clr_n = 1'b1;
      end
      @(posedge clk);
      if (!load_n) begin
        m = int'(d); mo = 0;
      end else if (enp && ent) begin
        wrapped = up ? (m >= M - 1) : (m == 0);
        m = ref_step(m, up);
        if (wrapped) mo = 1;
      end
      #1;
      check_eq("rnd_q", q, m);
`ifdef TTL_SYNC_COUNTER_OVF_EN
      check_eq("rnd_ovf", ovf, mo);
`endif
    end
    load_n = 1'b1; enp = 1'b0;

    // Two-digit cascade: 00..99 then 00.
    c_d = '0; c_load_n = 1'b0; c_enp = 1'b1;
    tick();
    c_load_n = 1'b1;
    check_eq("casc_load", int'(t_q) * 10 + int'(u_q), 0);
    n = 0; c_ovf = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      n = (n + 1) % 100;
      if (n == 0) c_ovf = 1;
      check_eq("casc_count", int'(t_q) * 10 + int'(u_q), n);
`ifdef TTL_SYNC_COUNTER_OVF_EN
      check_eq("casc_tens_ovf", t_ovf, c_ovf);
`endif
    end
    c_load_n = 1'b0;
    tick();
    c_load_n = 1'b1;
    check_eq("casc_reload", int'(t_q) * 10 + int'(u_q), 0);
`ifdef TTL_SYNC_COUNTER_OVF_EN
    check_eq("casc_ovf_cleared", t_ovf, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
